// File: rtl/sdram_read_responder.sv
// Responder for sdram_read_intf: fetches read_cnt words over Avalon-MM in bursts of up to MAX_BURST.
// Define SDRAM_RD_TIMEOUT_EN to build the stuck-slave watchdog that drives read_timeout.
module sdram_read_responder #(
  parameter int DATA_W         = 16,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       read_addr,
  input  logic [10:0]       read_cnt,
  input  logic              read_start,
  output logic              read_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              read_done,
  output logic              read_busy,
  output logic              read_timeout,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic [7:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int unsigned BYTES        = DATA_W / 8;
  localparam logic [10:0] MAX_BURST_11 = 11'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RECV   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] cur_addr_r;
  logic [10:0] remaining_r;
  logic [7:0]  beat_cnt_r;
  logic [31:0] next_addr_s;
  logic        beat_s;
  logic        waiting_s;
  logic        handshake_s;
  logic        abort_s;

  function automatic logic [7:0] burst_len(input logic [10:0] rem);
    if (rem > MAX_BURST_11) begin
      burst_len = 8'(MAX_BURST);
    end else begin
      burst_len = rem[7:0];
    end
  endfunction

  // Beat/handshake qualification and address of the following burst
  always_comb begin
    beat_s      = (state_r == RECV) && avm_readdatavalid && (beat_cnt_r != 8'd0);
    waiting_s   = (state_r == ISSUE) || ((state_r == RECV) && (beat_cnt_r != 8'd0));
    handshake_s = ((state_r == ISSUE) && !avm_waitrequest) || beat_s;
    next_addr_s = cur_addr_r + ({24'd0, avm_burstcount} * 32'(BYTES));
  end

`ifdef SDRAM_RD_TIMEOUT_EN
  logic [31:0] wd_cnt_r;
  logic        timeout_r;

  assign abort_s      = waiting_s && !handshake_s && (wd_cnt_r == 32'(TIMEOUT_CYCLES - 1));
  assign read_timeout = timeout_r;

  // Watchdog: counts consecutive handshake-free cycles while a burst is pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_r  <= 32'd0;
      timeout_r <= 1'b0;
    end else begin
      if (waiting_s && !handshake_s) begin
        wd_cnt_r <= wd_cnt_r + 32'd1;
      end else begin
        wd_cnt_r <= 32'd0;
      end
      if ((state_r == IDLE) && read_start) begin
        timeout_r <= 1'b0;
      end else if (abort_s) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end
`else
  assign abort_s      = 1'b0;
  assign read_timeout = 1'b0;
`endif

  // Command FSM; every output is a register so the interface is glitch-free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cur_addr_r     <= 32'd0;
      remaining_r    <= 11'd0;
      beat_cnt_r     <= 8'd0;
      read_valid     <= 1'b0;
      read_data      <= {DATA_W{1'b0}};
      read_done      <= 1'b0;
      read_busy      <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= 32'd0;
      avm_burstcount <= 8'd0;
    end else begin
      read_valid <= 1'b0;
      read_done  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (read_start) begin
            cur_addr_r  <= read_addr;
            remaining_r <= read_cnt;
            read_busy   <= 1'b1;
            if (read_cnt == 11'd0) begin
              state_r   <= FINISH;
              read_done <= 1'b1;
            end else begin
              state_r        <= ISSUE;
              avm_read       <= 1'b1;
              avm_address    <= read_addr;
              avm_burstcount <= burst_len(read_cnt);
            end
          end
        end
        ISSUE: begin
          if (abort_s) begin
            state_r   <= FINISH;
            read_done <= 1'b1;
            avm_read  <= 1'b0;
          end else if (!avm_waitrequest) begin
            avm_read   <= 1'b0;
            beat_cnt_r <= avm_burstcount;
            state_r    <= RECV;
          end
        end
        RECV: begin
          // beat_cnt_r == 0 here only after the final beat, so read_done lands one cycle after it
          if (abort_s) begin
            state_r   <= FINISH;
            read_done <= 1'b1;
          end else if (beat_cnt_r == 8'd0) begin
            state_r   <= FINISH;
            read_done <= 1'b1;
          end else if (beat_s) begin
            read_valid  <= 1'b1;
            read_data   <= avm_readdata;
            beat_cnt_r  <= beat_cnt_r - 8'd1;
            remaining_r <= remaining_r - 11'd1;
            if ((beat_cnt_r == 8'd1) && (remaining_r != 11'd1)) begin
              cur_addr_r     <= next_addr_s;
              avm_address    <= next_addr_s;
              avm_burstcount <= burst_len(remaining_r - 11'd1);
              avm_read       <= 1'b1;
              state_r        <= ISSUE;
            end
          end
        end
        FINISH: begin
          read_busy <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_read_responder.sv
// Randomized bench for sdram_read_responder: a slave model plus a burst/data reference built from the command.
`timescale 1ns/1ps
module tb_sdram_read_responder;
  localparam int DW    = 16;
  localparam int MB    = 8;
  localparam int BYTES = DW / 8;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   read_addr;
  logic [10:0]   read_cnt;
  logic          read_start;
  logic          read_valid;
  logic [DW-1:0] read_data;
  logic          read_done;
  logic          read_busy;
  logic          read_timeout;
  logic [31:0]   avm_address;
  logic          avm_read;
  logic [7:0]    avm_burstcount;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_read_responder #(.DATA_W(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_addr(read_addr), .read_cnt(read_cnt), .read_start(read_start),
    .read_valid(read_valid), .read_data(read_data), .read_done(read_done),
    .read_busy(read_busy), .read_timeout(read_timeout),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  // Slave memory contents: a fixed hash of the byte address
  function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h045D_9F3B) ^ 32'h5A5A_1234;
    return h[31:16] ^ a[16:1];
  endfunction

  task automatic do_cmd(input string tag, input logic [31:0] addr, input logic [10:0] cnt,
                        input int wmin, input int wmax, input int gap_pct,
                        input bit spam, input int stop_after, input bit exp_to);
    logic [31:0]   ba[$];
    logic [7:0]    bb[$];
    logic [DW-1:0] ed[$];
    logic [31:0]   a, paddr, prev_a;
    logic [7:0]    prev_b;
    logic [DW-1:0] last_d;
    int rem, b, got, done_n, last_valid, pend, bidx, wait_left, returned, budget, post, exp_got, exp_b;
    bit rdv_prev, stalled, accepted_now;
    rem = int'(cnt);
    a = addr;
    while (rem > 0) begin
      b = (rem > MB) ? MB : rem;
      ba.push_back(a);
      bb.push_back(8'(b));
      a = a + 32'(b * BYTES);
      rem = rem - b;
    end
    for (int i = 0; i < int'(cnt); i++) ed.push_back(mem_word(addr + 32'(i * BYTES)));
    got = 0; done_n = 0; last_valid = -100; pend = 0; bidx = 0; wait_left = 0;
    returned = 0; post = 0; rdv_prev = 1'b0; stalled = 1'b0; paddr = 32'd0;
    prev_a = 32'd0; prev_b = 8'd0; last_d = '0;
    @(negedge clk);
    read_start = 1'b1; read_addr = addr; read_cnt = cnt;
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    @(negedge clk);
    read_start = 1'b0; read_addr = 32'd0; read_cnt = 11'd0;
    budget = 200 + int'(cnt) * (wmax + 20);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      n_tests++;
      if (read_valid !== rdv_prev) begin
        n_fail++; $display("FAIL %s valid_latency cyc %0d: got %b expected %b", tag, cyc, read_valid, rdv_prev);
      end
      if (cyc == 1) begin
        n_tests++;
        if (read_busy !== 1'b1) begin
          n_fail++; $display("FAIL %s busy_after_accept: got %b expected 1", tag, read_busy);
        end
      end
      if (!exp_to) begin
        n_tests++;
        if (read_timeout !== 1'b0) begin
          n_fail++; $display("FAIL %s timeout_flag cyc %0d: got %b expected 0", tag, cyc, read_timeout);
        end
      end
      if (read_valid === 1'b1) begin
        n_tests++;
        if (got >= ed.size()) begin
          n_fail++; $display("FAIL %s extra_valid: got word %0d expected only %0d words", tag, got + 1, ed.size());
        end else if (read_data !== ed[got]) begin
          n_fail++; $display("FAIL %s data[%0d]: got %h expected %h", tag, got, read_data, ed[got]);
        end
        last_d = read_data; got++; last_valid = cyc;
      end else if (got > 0) begin
        n_tests++;
        if (read_data !== last_d) begin
          n_fail++; $display("FAIL %s data_hold cyc %0d: got %h expected %h", tag, cyc, read_data, last_d);
        end
      end
      if (read_done === 1'b1) begin
        done_n++;
        n_tests++;
        if (read_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s done_with_valid: got valid %b expected 0", tag, read_valid);
        end
        n_tests++;
        if (exp_to) begin
          if (cyc != last_valid + TO || read_timeout !== 1'b1) begin
            n_fail++; $display("FAIL %s timeout_done: got cyc %0d flag %b expected cyc %0d flag 1", tag, cyc, read_timeout, last_valid + TO);
          end
        end else if (cnt == 11'd0) begin
          if (cyc != 1) begin
            n_fail++; $display("FAIL %s zero_done_latency: got cyc %0d expected 1", tag, cyc);
          end
        end else if (cyc != last_valid + 1) begin
          n_fail++; $display("FAIL %s done_latency: got cyc %0d expected %0d", tag, cyc, last_valid + 1);
        end
      end
      accepted_now = 1'b0;
      if (stalled) begin
        n_tests++;
        if (avm_read !== 1'b1 || avm_address !== prev_a || avm_burstcount !== prev_b) begin
          n_fail++; $display("FAIL %s stall_stable: got rd %b addr %h bc %0d expected 1 %h %0d", tag, avm_read, avm_address, avm_burstcount, prev_a, prev_b);
        end
      end else if (avm_read === 1'b1) begin
        n_tests++;
        if (bidx >= ba.size()) begin
          n_fail++; $display("FAIL %s extra_request: got addr %h bc %0d expected no request", tag, avm_address, avm_burstcount);
        end else if (avm_address !== ba[bidx] || avm_burstcount !== bb[bidx]) begin
          n_fail++; $display("FAIL %s burst[%0d]: got %h/%0d expected %h/%0d", tag, bidx, avm_address, avm_burstcount, ba[bidx], bb[bidx]);
        end
        wait_left = $urandom_range(wmax, wmin);
      end
      if (avm_read === 1'b1) begin
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1; wait_left--; stalled = 1'b1;
          prev_a = avm_address; prev_b = avm_burstcount;
        end else begin
          avm_waitrequest = 1'b0; stalled = 1'b0; accepted_now = 1'b1;
          pend = pend + int'(avm_burstcount); paddr = avm_address; bidx++;
        end
      end else begin
        avm_waitrequest = ($urandom_range(1, 0) == 1); stalled = 1'b0;
      end
      if (pend > 0 && !accepted_now && (stop_after < 0 || returned < stop_after) &&
          $urandom_range(99, 0) >= gap_pct) begin
        avm_readdatavalid = 1'b1; avm_readdata = mem_word(paddr);
        paddr = paddr + 32'(BYTES); pend--; returned++;
      end else begin
        avm_readdatavalid = 1'b0; avm_readdata = DW'($urandom);
      end
      rdv_prev = avm_readdatavalid;
      if (spam) begin
        read_addr = 32'h0000_0900; read_cnt = 11'd3;
        if (read_done === 1'b1) read_start = 1'b1;
        else if (done_n == 0) read_start = ($urandom_range(1, 0) == 1);
        else read_start = 1'b0;
      end
      if (done_n > 0) begin
        post++;
        if (post > 4) break;
      end
      @(negedge clk);
    end
    read_start = 1'b0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    exp_got = exp_to ? stop_after : int'(cnt);
    exp_b   = exp_to ? 1 : ba.size();
    n_tests++;
    if (done_n != 1) begin
      n_fail++; $display("FAIL %s done_count: got %0d expected 1", tag, done_n);
    end
    n_tests++;
    if (got != exp_got) begin
      n_fail++; $display("FAIL %s valid_count: got %0d expected %0d", tag, got, exp_got);
    end
    n_tests++;
    if (bidx != exp_b) begin
      n_fail++; $display("FAIL %s burst_count: got %0d expected %0d", tag, bidx, exp_b);
    end
    n_tests++;
    if (read_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_after_done: got %b expected 0", tag, read_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({read_valid, read_data, read_done, read_busy, read_timeout, avm_read, avm_address, avm_burstcount} !== 61'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
        {read_valid, read_data, read_done, read_busy, read_timeout, avm_read, avm_address, avm_burstcount});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    do_cmd("single", 32'h0000_0100, 11'd5, 0, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_split_stall();
    do_cmd("split_stall", 32'h0000_0100, 11'd20, 3, 3, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_zero_count();
    do_cmd("zero_cnt", 32'h0000_0300, 11'd0, 0, 2, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_cmd("busy_ignore", 32'h0000_0200, 11'd12, 0, 2, 20, 1'b1, -1, 1'b0);
    do_cmd("after_busy", 32'h0000_0900, 11'd3, 0, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_boundaries();
    do_cmd("exact_burst", 32'h0000_1000, 11'd8, 0, 1, 0, 1'b0, -1, 1'b0);
    do_cmd("burst_plus1", 32'h0000_2001, 11'd9, 0, 1, 10, 1'b0, -1, 1'b0);
    do_cmd("one_word", 32'h0000_3000, 11'd1, 0, 0, 0, 1'b0, -1, 1'b0);
    do_cmd("addr_wrap", 32'hFFFF_FFF0, 11'd20, 1, 2, 20, 1'b0, -1, 1'b0);
    do_cmd("max_cnt", $urandom, 11'd2047, 0, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_cmd("random", $urandom, 11'($urandom_range(40, 0)), 0, $urandom_range(4, 0),
             $urandom_range(40, 0), 1'b0, -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    read_start = 1'b1; read_addr = 32'h0000_4000; read_cnt = 11'd20;
    @(negedge clk);
    read_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      avm_waitrequest = 1'b0; avm_readdatavalid = (i >= 2); avm_readdata = DW'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({read_valid, read_data, read_done, read_busy, read_timeout, avm_read, avm_address, avm_burstcount} !== 61'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0",
        {read_valid, read_data, read_done, read_busy, read_timeout, avm_read, avm_address, avm_burstcount});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      avm_readdatavalid = 1'b1; avm_readdata = DW'($urandom);
      @(negedge clk);
      n_tests++;
      if ({read_valid, read_done, read_busy, avm_read} !== 4'd0) begin
        n_fail++; $display("FAIL stale_beat_ignored: got v/d/b/r %b expected 0000", {read_valid, read_done, read_busy, avm_read});
      end
    end
    avm_readdatavalid = 1'b0;
    do_cmd("after_reset", 32'h0000_5000, 11'd11, 0, 2, 20, 1'b0, -1, 1'b0);
  endtask

`ifdef SDRAM_RD_TIMEOUT_EN
  task automatic test_timeout();
    do_cmd("timeout", 32'h0000_6000, 11'd8, 0, 0, 0, 1'b0, 2, 1'b1);
    n_tests++;
    if (read_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b expected 1", read_timeout);
    end
    do_cmd("after_timeout", 32'h0000_7000, 11'd4, 0, 1, 0, 1'b0, -1, 1'b0);
  endtask
`endif

  initial begin
    rst_n = 1'b0; read_start = 1'b0; read_addr = 32'd0; read_cnt = 11'd0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    test_reset();
    test_single_burst();
    test_split_stall();
    test_zero_count();
    test_busy_ignore();
    test_boundaries();
    test_random();
    test_reset_mid();
`ifdef SDRAM_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
